// File: rtl/memshare_rqst_sched_pkg.sv
// Shared configuration and types for the message-pass buffer read scheduler.
// Optional perf counters are enabled with MEMSHARE_SCHED_PERF_CNT_EN.
package memshare_rqst_sched_pkg;

    localparam int unsigned MSGPASS_BASEADDR_NUM       = 4;
    localparam int unsigned MSGPASS_SCHED_RQST_NUM     = 4;
    localparam int unsigned MSGPASS_SCHED_OFFSET_WIDTH = 5;
    localparam int unsigned MSGPASS_SCHED_BURST_MAX    = 8;

    localparam int unsigned MSGPASS_SCHED_SEL_W = $clog2(MSGPASS_BASEADDR_NUM);
    localparam int unsigned MSGPASS_SCHED_LEN_W = $clog2(MSGPASS_SCHED_BURST_MAX);
    localparam int unsigned MSGPASS_SCHED_TAG_W = $clog2(MSGPASS_SCHED_RQST_NUM);

    typedef enum logic [0:0] {SCHED_IDLE, SCHED_BURST} sched_state_e;

    // One requester's read descriptor at the default configuration.
    typedef struct packed {
        logic [MSGPASS_SCHED_SEL_W-1:0]        sel;
        logic [MSGPASS_SCHED_OFFSET_WIDTH-1:0] offset;
        logic [MSGPASS_SCHED_LEN_W-1:0]        len;
    } sched_rqst_t;

endpackage

// File: rtl/memshare_rr_arbiter.sv
// Combinational round-robin arbiter: first valid at or above ptr, cyclically.
// Shared by the memShare read and write paths.
module memshare_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             found_c
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate down so the nearest one to ptr wins.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        found_c = 1'b0;
        cand    = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (valid[cand]) begin
                found_c = 1'b1;
                idx_c   = cand;
                grant_c = N'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/memshare_rqst_sched.sv
// Round-robin scheduler sharing the message-pass buffer read path among memShare requesters.
// Define MEMSHARE_SCHED_PERF_CNT_EN to enable the grant/busy perf counters.
module memshare_rqst_sched
    import memshare_rqst_sched_pkg::*;
#(
    parameter int unsigned RQST_NUM     = MSGPASS_SCHED_RQST_NUM,
    parameter int unsigned BASE_NUM     = MSGPASS_BASEADDR_NUM,
    parameter int unsigned OFFSET_WIDTH = MSGPASS_SCHED_OFFSET_WIDTH,
    parameter int unsigned BURST_MAX    = MSGPASS_SCHED_BURST_MAX
) (
    input  logic                                  sys_clk,
    input  logic                                  rst,
    input  logic [RQST_NUM-1:0]                   rqst_valid_i,
    input  logic [RQST_NUM*$clog2(BASE_NUM)-1:0]  rqst_base_sel_i,
    input  logic [RQST_NUM*OFFSET_WIDTH-1:0]      rqst_offset_i,
    input  logic [RQST_NUM*$clog2(BURST_MAX)-1:0] rqst_len_i,
    output logic [RQST_NUM-1:0]                   rqst_ack_o,
    output logic [RQST_NUM-1:0]                   rqst_done_o,
    output logic [$clog2(BASE_NUM)-1:0]           baseAddr_sel_o,
    output logic                                  rd_valid_o,
    output logic [OFFSET_WIDTH-1:0]               rd_offset_o,
    output logic [$clog2(RQST_NUM)-1:0]           rd_tag_o,
    output logic                                  rd_last_o,
    output logic                                  busy_o,
    output logic [RQST_NUM*16-1:0]                perf_grant_cnt_o,
    output logic [31:0]                           perf_busy_cnt_o
);

    localparam int unsigned SEL_W = $clog2(BASE_NUM);
    localparam int unsigned LEN_W = $clog2(BURST_MAX);
    localparam int unsigned TAG_W = $clog2(RQST_NUM);

    sched_state_e       state;
    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   owner;
    logic [SEL_W-1:0]   sel_q;
    logic [OFFSET_WIDTH-1:0] offset_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_cnt;

    logic [RQST_NUM-1:0] arb_grant;
    logic [TAG_W-1:0]    arb_idx;
    logic                arb_found;
    logic                last_beat_c;

    memshare_rr_arbiter #(
        .N     (RQST_NUM),
        .IDX_W (TAG_W)
    ) u_arb (
        .valid   (rqst_valid_i),
        .ptr     (rr_ptr),
        .grant_c (arb_grant),
        .idx_c   (arb_idx),
        .found_c (arb_found)
    );

    assign last_beat_c    = (state == SCHED_BURST) && (beat_cnt == len_q);
    assign rqst_ack_o     = (state == SCHED_IDLE && arb_found) ? arb_grant : '0;
    assign rqst_done_o    = last_beat_c ? (RQST_NUM'(1) << owner) : '0;
    assign busy_o         = (state == SCHED_BURST);
    assign baseAddr_sel_o = sel_q;

    // Grant/sequence FSM; rd_* is the one-cycle pipeline matching the rebase stage.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= SCHED_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            sel_q       <= '0;
            offset_q    <= '0;
            len_q       <= '0;
            beat_cnt    <= '0;
            rd_valid_o  <= 1'b0;
            rd_offset_o <= '0;
            rd_tag_o    <= '0;
            rd_last_o   <= 1'b0;
        end else begin
            rd_valid_o  <= 1'b0;
            rd_offset_o <= '0;
            rd_tag_o    <= '0;
            rd_last_o   <= 1'b0;
            case (state)
                SCHED_IDLE: begin
                    if (arb_found) begin
                        owner    <= arb_idx;
                        sel_q    <= rqst_base_sel_i[32'(arb_idx)*SEL_W +: SEL_W];
                        offset_q <= rqst_offset_i[32'(arb_idx)*OFFSET_WIDTH +: OFFSET_WIDTH];
                        len_q    <= rqst_len_i[32'(arb_idx)*LEN_W +: LEN_W];
                        beat_cnt <= '0;
                        state    <= SCHED_BURST;
                    end
                end
                SCHED_BURST: begin
                    rd_valid_o  <= 1'b1;
                    rd_offset_o <= offset_q + OFFSET_WIDTH'(beat_cnt);
                    rd_tag_o    <= owner;
                    rd_last_o   <= last_beat_c;
                    if (last_beat_c) begin
                        rr_ptr   <= owner + TAG_W'(1);
                        beat_cnt <= '0;
                        state    <= SCHED_IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                    end
                end
                default: state <= SCHED_IDLE;
            endcase
        end
    end

`ifdef MEMSHARE_SCHED_PERF_CNT_EN
    logic [15:0] grant_cnt [RQST_NUM];
    logic [31:0] busy_cnt;

    // Saturating per-requester grant counts and a wrapping busy-cycle count.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RQST_NUM); i++) grant_cnt[i] <= '0;
            busy_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(RQST_NUM); i++) begin
                if (rqst_ack_o[i] && grant_cnt[i] != 16'hFFFF) grant_cnt[i] <= grant_cnt[i] + 16'(1);
            end
            if (busy_o) busy_cnt <= busy_cnt + 32'(1);
        end
    end

    always_comb begin
        perf_grant_cnt_o = '0;
        for (int i = 0; i < int'(RQST_NUM); i++) perf_grant_cnt_o[i*16 +: 16] = grant_cnt[i];
    end
    assign perf_busy_cnt_o = busy_cnt;
`else
    assign perf_grant_cnt_o = '0;
    assign perf_busy_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_memshare_rqst_sched.sv
// Scoreboard bench for memshare_rqst_sched: expected beats are queued at request time
// and popped by a negedge monitor; grant/done timing is checked inline.
module tb_memshare_rqst_sched;
    import memshare_rqst_sched_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;
    localparam int unsigned OW = 5;
    localparam int unsigned LW = 3;
    localparam int unsigned TW = 2;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [SW-1:0] sel;
        logic [OW-1:0] off;
        logic          last;
    } beat_t;

    logic            sys_clk = 1'b0;
    logic            rst     = 1'b1;
    logic [N-1:0]    rqst_valid_i    = '0;
    logic [N*SW-1:0] rqst_base_sel_i = '0;
    logic [N*OW-1:0] rqst_offset_i   = '0;
    logic [N*LW-1:0] rqst_len_i      = '0;
    logic [N-1:0]    rqst_ack_o;
    logic [N-1:0]    rqst_done_o;
    logic [SW-1:0]   baseAddr_sel_o;
    logic            rd_valid_o;
    logic [OW-1:0]   rd_offset_o;
    logic [TW-1:0]   rd_tag_o;
    logic            rd_last_o;
    logic            busy_o;
    logic [N*16-1:0] perf_grant_cnt_o;
    logic [31:0]     perf_busy_cnt_o;

    memshare_rqst_sched dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .rqst_valid_i     (rqst_valid_i),
        .rqst_base_sel_i  (rqst_base_sel_i),
        .rqst_offset_i    (rqst_offset_i),
        .rqst_len_i       (rqst_len_i),
        .rqst_ack_o       (rqst_ack_o),
        .rqst_done_o      (rqst_done_o),
        .baseAddr_sel_o   (baseAddr_sel_o),
        .rd_valid_o       (rd_valid_o),
        .rd_offset_o      (rd_offset_o),
        .rd_tag_o         (rd_tag_o),
        .rd_last_o        (rd_last_o),
        .busy_o           (busy_o),
        .perf_grant_cnt_o (perf_grant_cnt_o),
        .perf_busy_cnt_o  (perf_busy_cnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];
    beat_t mon_e;
    logic [SW-1:0] prev_sel = '0;
    bit    mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_rqst(input int idx, input sched_rqst_t r);
        rqst_base_sel_i[idx*SW +: SW] = r.sel;
        rqst_offset_i[idx*OW +: OW]   = r.offset;
        rqst_len_i[idx*LW +: LW]      = r.len;
    endtask

    // Queue the first nb beats a granted request is expected to produce.
    task automatic push_burst(input int tag, input sched_rqst_t r, input int nb);
        beat_t e;
        for (int k = 0; k < nb; k++) begin
            e.tag  = TW'(tag);
            e.sel  = r.sel;
            e.off  = OW'(int'(r.offset) + k);
            e.last = (k == int'(r.len));
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_ack(input int idx, input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge sys_clk);
            if (rqst_ack_o != '0) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check(tag, seen ? 32'(rqst_ack_o) : 32'hDEAD_BEEF, 32'(N'(1) << idx));
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 40; c++) begin
            if (exp_q.size() == 0 && !busy_o && !rd_valid_o) break;
            step();
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Beat monitor: rd_* at T+1 must match the queue; the select seen at T must match too.
    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (rd_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_offset", 32'(rd_offset_o), 32'(mon_e.off));
                    check("beat_tag", 32'(rd_tag_o), 32'(mon_e.tag));
                    check("beat_last", 32'(rd_last_o), 32'(mon_e.last));
                    check("beat_sel", 32'(prev_sel), 32'(mon_e.sel));
                end
            end else begin
                check("idle_rd_zero", 32'({rd_tag_o, rd_offset_o, rd_last_o}), 32'd0);
            end
        end
        prev_sel = baseAddr_sel_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sched_rqst_t r;
        int busy_cycles;

        // Reset state
        repeat (3) step();
        check("rst_rd_valid", 32'(rd_valid_o), 32'd0);
        check("rst_rd_fields", 32'({rd_tag_o, rd_offset_o, rd_last_o}), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_sel", 32'(baseAddr_sel_o), 32'd0);
        check("rst_ack_done", 32'({rqst_ack_o, rqst_done_o}), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single request: requester 2, sel 3, offset 4, len 2
        r = '{sel: 2'd3, offset: 5'd4, len: 3'd2};
        push_burst(2, r, 3);
        set_rqst(2, r);
        rqst_valid_i = 4'b0100;
        @(negedge sys_clk);
        check("t1_ack", 32'(rqst_ack_o), 32'h4);
        check("t1_busy_idle", 32'(busy_o), 32'd0);
        step();
        rqst_valid_i = '0;
        for (int c = 2; c <= 4; c++) begin
            @(negedge sys_clk);
            check("t1_sel", 32'(baseAddr_sel_o), 32'd3);
            check("t1_busy", 32'(busy_o), 32'd1);
            check("t1_done", 32'(rqst_done_o), (c == 4) ? 32'h4 : 32'h0);
            check("t1_ack_burst", 32'(rqst_ack_o), 32'h0);
            step();
        end
        @(negedge sys_clk);
        check("t1_busy_after", 32'(busy_o), 32'd0);
        check("t1_sel_hold", 32'(baseAddr_sel_o), 32'd3);
        drain("t1_drain");

        // Offset wrap: requester 3, offset 30, len 3
        r = '{sel: 2'd1, offset: 5'd30, len: 3'd3};
        push_burst(3, r, 4);
        set_rqst(3, r);
        rqst_valid_i = 4'b1000;
        wait_ack(3, "t2_ack");
        step();
        rqst_valid_i = '0;
        drain("t2_drain");

        // Round-robin: all four valid, len 0; rr_ptr restarts from 0 here
        for (int i = 0; i < 4; i++) begin
            r = '{sel: SW'(i), offset: OW'(i * 8 + 1), len: 3'd0};
            set_rqst(i, r);
        end
        for (int g = 0; g < 5; g++) begin
            r = '{sel: SW'(g % 4), offset: OW'((g % 4) * 8 + 1), len: 3'd0};
            push_burst(g % 4, r, 1);
        end
        rqst_valid_i = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            @(negedge sys_clk);
            check("t3_ack", 32'(rqst_ack_o), 32'(N'(1) << (g % 4)));
            check("t3_done_idle", 32'(rqst_done_o), 32'h0);
            step();
            if (g == 4) rqst_valid_i = '0;
            @(negedge sys_clk);
            check("t3_done", 32'(rqst_done_o), 32'(N'(1) << (g % 4)));
            check("t3_ack_burst", 32'(rqst_ack_o), 32'h0);
            check("t3_busy", 32'(busy_o), 32'd1);
            step();
        end
        drain("t3_drain");

        // Mid-burst valid drop: requester 1, 8 beats
        r = '{sel: 2'd2, offset: 5'd10, len: 3'd7};
        push_burst(1, r, 8);
        set_rqst(1, r);
        rqst_valid_i = 4'b0010;
        @(negedge sys_clk);
        check("t4_ack", 32'(rqst_ack_o), 32'h2);
        step();
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            check("t4_busy", 32'(busy_o), 32'd1);
            check("t4_done", 32'(rqst_done_o), (k == 7) ? 32'h2 : 32'h0);
            if (k == 2) rqst_valid_i = '0;
            step();
        end
        @(negedge sys_clk);
        check("t4_busy_after", 32'(busy_o), 32'd0);
        drain("t4_drain");

        // Max burst: requester 2, len 7, busy for exactly 8 cycles
        r = '{sel: 2'd0, offset: 5'd31, len: 3'd7};
        push_burst(2, r, 8);
        set_rqst(2, r);
        rqst_valid_i = 4'b0100;
        wait_ack(2, "t5_ack");
        step();
        rqst_valid_i = '0;
        busy_cycles  = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge sys_clk);
            if (busy_o) busy_cycles++;
            step();
        end
        check("t5_busy_cycles", 32'(busy_cycles), 32'd8);
        drain("t5_drain");

        // Reset mid-burst of requester 0; only the first two beats reach rd_*
        r = '{sel: 2'd1, offset: 5'd7, len: 3'd5};
        push_burst(0, r, 2);
        set_rqst(0, r);
        rqst_valid_i = 4'b0001;
        @(negedge sys_clk);
        check("t6_ack", 32'(rqst_ack_o), 32'h1);
        step();
        rqst_valid_i = '0;
        @(negedge sys_clk);
        step();
        @(negedge sys_clk);
        step();
        rst = 1'b1;
        @(negedge sys_clk);
        check("t6_done_pre", 32'(rqst_done_o), 32'h0);
        step();
        @(negedge sys_clk);
        check("t6_rdv_after_rst", 32'(rd_valid_o), 32'd0);
        check("t6_no_done", 32'(rqst_done_o), 32'h0);
        check("t6_busy_after_rst", 32'(busy_o), 32'd0);
        step();
        rst = 1'b0;
        r = '{sel: 2'd3, offset: 5'd2, len: 3'd0};
        set_rqst(1, r);
        push_burst(1, r, 1);
        r = '{sel: 2'd2, offset: 5'd9, len: 3'd0};
        set_rqst(3, r);
        push_burst(3, r, 1);
        rqst_valid_i = 4'b1010;
        @(negedge sys_clk);
        check("t6_rr_restart", 32'(rqst_ack_o), 32'h2);
        step();
        rqst_valid_i = 4'b1000;
        wait_ack(3, "t6_ack3");
        step();
        rqst_valid_i = '0;
        drain("t6_drain");

`ifdef MEMSHARE_SCHED_PERF_CNT_EN
        check("perf_grant0", 32'(perf_grant_cnt_o[15:0]), 32'd0);
        check("perf_grant1", 32'(perf_grant_cnt_o[31:16]), 32'd1);
        check("perf_grant2", 32'(perf_grant_cnt_o[47:32]), 32'd0);
        check("perf_grant3", 32'(perf_grant_cnt_o[63:48]), 32'd1);
        check("perf_busy", perf_busy_cnt_o, 32'd2);
`else
        check("perf_grant_tied", 32'(perf_grant_cnt_o != '0), 32'd0);
        check("perf_busy_tied", perf_busy_cnt_o, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
